// File: rtl/adder_responder.sv
// adder_responder: accepts operand pairs on a valid/ready request channel,
// queues their zero-extended sums in a small FIFO and returns them in order
// on a valid/ready response channel. Counts consumed responses and carries.
module adder_responder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   c,
    output logic [CNT_W-1:0] rsp_count,
    output logic [CNT_W-1:0] carry_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] rsp_count_q, rsp_count_d;
    logic [CNT_W-1:0] carry_count_q, carry_count_d;
    logic [WIDTH:0]   sum;
    logic             push;
    logic             pop;

    // Handshake flags come from registered occupancy only, so rsp_ready
    // never reaches req_ready combinationally.
    assign req_ready   = (occ_q < OCC_FULL);
    assign rsp_valid   = (occ_q != '0);
    assign c           = mem_q[rd_ptr_q];
    assign rsp_count   = rsp_count_q;
    assign carry_count = carry_count_q;

    // Next-state: pointer advance, occupancy bookkeeping and pop statistics.
    always_comb begin
        push          = req_valid && req_ready;
        pop           = rsp_valid && rsp_ready;
        sum           = {1'b0, a} + {1'b0, b};
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        occ_d         = occ_q;
        rsp_count_d   = rsp_count_q;
        carry_count_d = carry_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            rsp_count_d = rsp_count_q + CNT_ONE;
            if (c[WIDTH]) begin
                carry_count_d = carry_count_q + CNT_ONE;
            end
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Control state register; reset flushes the queue and clears counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            rsp_count_q   <= '0;
            carry_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            rsp_count_q   <= rsp_count_d;
            carry_count_q <= carry_count_d;
        end
    end

    // Result storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= sum;
        end
    end

endmodule

// File: tb/tb_adder_responder.sv
// Self-checking bench for adder_responder: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_adder_responder;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MOD = 1 << CNT_W;
    localparam int          CARRY_V = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH:0]   c;
    logic [CNT_W-1:0] rsp_count;
    logic [CNT_W-1:0] carry_count;

    int vectors;
    int miscompares;
    int exp_q[$];
    int exp_rsp;
    int exp_carry;

    adder_responder #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a          (a),
        .b          (b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .c          (c),
        .rsp_count  (rsp_count),
        .carry_count(carry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and apply the reference model's view of it.
    task automatic tick();
        bit do_push;
        bit do_pop;
        int new_sum;
        int head;
        do_push = !rst && req_valid && (exp_q.size() < DEPTH);
        do_pop  = !rst && rsp_ready && (exp_q.size() != 0);
        new_sum = int'(a) + int'(b);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_rsp   = 0;
            exp_carry = 0;
        end else begin
            if (do_pop) begin
                head    = exp_q.pop_front();
                exp_rsp = (exp_rsp + 1) % CNT_MOD;
                if (head >= CARRY_V) exp_carry = (exp_carry + 1) % CNT_MOD;
            end
            if (do_push) exp_q.push_back(new_sum);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        vectors++;
        if (rsp_count !== '0 || carry_count !== '0) begin
            miscompares++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", rsp_count, carry_count);
        end
    endtask

    task automatic test_basic();
        a = 4'd6; b = 4'd4; req_valid = 1'b1; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || c !== 5'd10) begin
            miscompares++;
            $display("FAIL basic_sum got valid=%b c=%0d want valid=1 c=10", rsp_valid, c);
        end
        tick();
        vectors++;
        if (rsp_count !== 8'd1 || carry_count !== 8'd0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_counters got rsp=%0d carry=%0d valid=%b want 1 0 0",
                     rsp_count, carry_count, rsp_valid);
        end
    endtask

    task automatic test_carry();
        a = 4'd15; b = 4'd15; req_valid = 1'b1; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (c !== 5'b11110) begin
            miscompares++; $display("FAIL carry_sum30 got %0d want 30", c);
        end
        tick();
        vectors++;
        if (carry_count !== 8'd1 || rsp_count !== 8'd2) begin
            miscompares++;
            $display("FAIL carry_count1 got carry=%0d rsp=%0d want 1 2", carry_count, rsp_count);
        end
        a = 4'd15; b = 4'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (c !== 5'd16) begin
            miscompares++; $display("FAIL carry_sum16 got %0d want 16", c);
        end
        tick();
        vectors++;
        if (carry_count !== 8'd2 || rsp_count !== 8'd3) begin
            miscompares++;
            $display("FAIL carry_count2 got carry=%0d rsp=%0d want 2 3", carry_count, rsp_count);
        end
    endtask

    task automatic test_full();
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            a = WIDTH'(i); b = WIDTH'(i); req_valid = 1'b1;
            tick();
            vectors++;
            if (req_ready !== (i < 4)) begin
                miscompares++;
                $display("FAIL full_req_ready push%0d got %b want %b", i, req_ready, (i < 4));
            end
            vectors++;
            if (c !== 5'd2 || rsp_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL full_hold push%0d got c=%0d valid=%b want 2 1", i, c, rsp_valid);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || c !== 5'(2 * (k + 1))) begin
                miscompares++;
                $display("FAIL full_drain%0d got c=%0d valid=%b want %0d 1", k, c, rsp_valid, 2 * (k + 1));
            end
            tick();
            vectors++;
            if (req_ready !== 1'b1) begin
                miscompares++; $display("FAIL full_reopen%0d got %b want 1", k, req_ready);
            end
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_count !== 8'd7 || carry_count !== 8'd2) begin
            miscompares++;
            $display("FAIL full_empty got valid=%b rsp=%0d carry=%0d want 0 7 2",
                     rsp_valid, rsp_count, carry_count);
        end
    endtask

    task automatic test_back_to_back();
        int want[5] = '{3, 7, 15, 15, 15};
        rsp_ready = 1'b0; req_valid = 1'b1;
        a = 4'd1; b = 4'd2; tick();
        a = 4'd3; b = 4'd4; tick();
        a = 4'd7; b = 4'd8; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) req_valid = 1'b0;
            vectors++;
            if (rsp_valid !== 1'b1 || c !== 5'(want[i])) begin
                miscompares++;
                $display("FAIL b2b_order%0d got c=%0d valid=%b want %0d 1", i, c, rsp_valid, want[i]);
            end
            if (i < 3) begin
                vectors++;
                if (req_ready !== 1'b1) begin
                    miscompares++; $display("FAIL b2b_ready%0d got %b want 1", i, req_ready);
                end
            end
            tick();
        end
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_empty got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = WIDTH'(i + 9); b = WIDTH'(i + 9);
            tick();
        end
        rst = 1'b1; rsp_ready = 1'b1;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_flags got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        vectors++;
        if (rsp_count !== '0 || carry_count !== '0) begin
            miscompares++;
            $display("FAIL midrst_counters got %0d/%0d want 0/0", rsp_count, carry_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b0 || rsp_count !== '0) begin
                miscompares++;
                $display("FAIL midrst_stale%0d got valid=%b rsp=%0d want 0 0", i, rsp_valid, rsp_count);
            end
        end
    endtask

    task automatic test_counter_wrap();
        a = '0; b = '0; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            tick();
            if (i == 256 || i == 257) begin
                vectors++;
                if (rsp_count !== CNT_W'((i - 1) % CNT_MOD) || carry_count !== '0) begin
                    miscompares++;
                    $display("FAIL wrap_tick%0d got rsp=%0d carry=%0d want %0d 0",
                             i, rsp_count, carry_count, (i - 1) % CNT_MOD);
                end
            end
        end
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            req_valid = 1'($urandom_range(0, 3) != 0);
            rsp_ready = 1'($urandom_range(0, 2) != 0);
            tick();
            vectors++;
            if (rsp_valid !== (exp_q.size() != 0) || req_ready !== (exp_q.size() < DEPTH)) begin
                miscompares++;
                $display("FAIL rand_flags%0d got valid=%b ready=%b want %b %b", i,
                         rsp_valid, req_ready, (exp_q.size() != 0), (exp_q.size() < DEPTH));
            end
            if (exp_q.size() != 0) begin
                vectors++;
                if (c !== 5'(exp_q[0])) begin
                    miscompares++; $display("FAIL rand_c%0d got %0d want %0d", i, c, exp_q[0]);
                end
            end
            vectors++;
            if (rsp_count !== CNT_W'(exp_rsp) || carry_count !== CNT_W'(exp_carry)) begin
                miscompares++;
                $display("FAIL rand_counters%0d got %0d/%0d want %0d/%0d", i,
                         rsp_count, carry_count, exp_rsp, exp_carry);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; exp_rsp = 0; exp_carry = 0;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_carry();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
